// File: rtl/ibex_rf_wb_arbiter.sv
// Register file write-port arbiter: LSU responses win, execute results bypass
// or wait in an in-order queue, with read-side forwarding of pending writes.
module ibex_rf_wb_arbiter #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned Depth     = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    input  logic [4:0]           raddr_a_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 fwd_a_valid_o,
    output logic                 fwd_b_valid_o,
    output logic [DataWidth-1:0] fwd_a_data_o,
    output logic [DataWidth-1:0] fwd_b_data_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 pending_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic                 valid_q [Depth];
    logic [4:0]           addr_q  [Depth];
    logic [DataWidth-1:0] data_q  [Depth];
    logic [CntW-1:0]      count_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [PtrW-1:0]      wr_ptr_q;

    logic ex_fire;
    logic bypass;
    logic enq;
    logic pop;
    logic lsu_kill;
    logic [DataWidth:0] fwd_a;
    logic [DataWidth:0] fwd_b;

    assign ex_ready_o = (32'(count_q) < Depth);
    assign ex_fire    = ex_valid_i && ex_ready_o;
    assign pop        = !lsu_valid_i && (count_q != '0);
    assign bypass     = !lsu_valid_i && (count_q == '0) && ex_fire;
    assign enq        = ex_fire && !bypass;
    assign lsu_kill   = lsu_valid_i && (lsu_waddr_i != 5'd0);
    assign pending_o  = (count_q != '0);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == Depth - 1) ? '0 : p + PtrW'(1);
    endfunction

    // Later matches overwrite earlier ones, so the sweep runs lowest to highest priority.
    function automatic logic [DataWidth:0] lookup(input logic [4:0] raddr);
        logic [DataWidth:0] r;
        logic [PtrW-1:0]    idx;
        r = '0;
        if (raddr != 5'd0) begin
            if (bypass && ex_waddr_i == raddr) r = {1'b1, ex_wdata_i};
            for (int unsigned i = 0; i < Depth; i++) begin
                idx = PtrW'((32'(rd_ptr_q) + i) % Depth);
                if (i < 32'(count_q) && valid_q[idx] && addr_q[idx] == raddr) begin
                    r = {1'b1, data_q[idx]};
                end
            end
            if (lsu_valid_i && lsu_waddr_i == raddr) r = {1'b1, lsu_wdata_i};
        end
        return r;
    endfunction

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (lsu_valid_i) begin
            rf_we_o    = (lsu_waddr_i != 5'd0);
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (count_q != '0) begin
            rf_we_o    = valid_q[rd_ptr_q] && (addr_q[rd_ptr_q] != 5'd0);
            rf_waddr_o = addr_q[rd_ptr_q];
            rf_wdata_o = data_q[rd_ptr_q];
        end else if (ex_fire) begin
            rf_we_o    = (ex_waddr_i != 5'd0);
            rf_waddr_o = ex_waddr_i;
            rf_wdata_o = ex_wdata_i;
        end
    end

    always_comb begin
        fwd_a         = lookup(raddr_a_i);
        fwd_b         = lookup(raddr_b_i);
        fwd_a_valid_o = fwd_a[DataWidth];
        fwd_a_data_o  = fwd_a[DataWidth-1:0];
        fwd_b_valid_o = fwd_b[DataWidth];
        fwd_b_data_o  = fwd_b[DataWidth-1:0];
    end

    // Kill is applied before the enqueue write so a same-cycle execute result survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            if (lsu_kill) begin
                for (int unsigned i = 0; i < Depth; i++) begin
                    if (addr_q[i] == lsu_waddr_i) valid_q[i] <= 1'b0;
                end
            end
            if (enq) begin
                valid_q[wr_ptr_q] <= 1'b1;
                addr_q[wr_ptr_q]  <= ex_waddr_i;
                data_q[wr_ptr_q]  <= ex_wdata_i;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CntW'(enq) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed bench for ibex_rf_wb_arbiter (DataWidth=32, Depth=2).
module tb_ibex_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic [4:0]  raddr_a_i;
    logic [4:0]  raddr_b_i;
    logic        fwd_a_valid_o;
    logic        fwd_b_valid_o;
    logic [31:0] fwd_a_data_o;
    logic [31:0] fwd_b_data_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_we_o;
    logic        pending_o;

    int checks   = 0;
    int failures = 0;

    ibex_rf_wb_arbiter #(.DataWidth(32), .Depth(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_waddr_i   (ex_waddr_i),
        .ex_wdata_i   (ex_wdata_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_waddr_i  (lsu_waddr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .fwd_a_valid_o(fwd_a_valid_o),
        .fwd_b_valid_o(fwd_b_valid_o),
        .fwd_a_data_o (fwd_a_data_o),
        .fwd_b_data_o (fwd_b_data_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .rf_we_o      (rf_we_o),
        .pending_o    (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; checks follow 1 time unit later.
    task automatic step(input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic ev, input logic [4:0] ea, input logic [31:0] ed);
        @(negedge clk_i);
        lsu_valid_i = lv;
        lsu_waddr_i = la;
        lsu_wdata_i = ld;
        ex_valid_i  = ev;
        ex_waddr_i  = ea;
        ex_wdata_i  = ed;
        #1;
    endtask

    task automatic chk_port(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(rf_we_o), 32'(we));
        if (we) begin
            chk({tag, "_waddr"}, 32'(rf_waddr_o), 32'(a));
            chk({tag, "_wdata"}, rf_wdata_o, d);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        {lsu_valid_i, ex_valid_i} = '0;
        lsu_waddr_i = '0; lsu_wdata_i = '0;
        ex_waddr_i  = '0; ex_wdata_i  = '0;
        raddr_a_i   = '0; raddr_b_i   = '0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // reset state
        step(0, 0, 0, 0, 0, 0);
        chk("rst_ready", 32'(ex_ready_o), 1);
        chk("rst_pending", 32'(pending_o), 0);
        chk("rst_we", 32'(rf_we_o), 0);
        chk("rst_fwd_a", 32'(fwd_a_valid_o), 0);

        // execute bypass
        raddr_a_i = 5'd5;
        step(0, 0, 0, 1, 5'd5, 32'h11);
        chk_port("bypass", 1, 5'd5, 32'h11);
        chk("bypass_fwd_v", 32'(fwd_a_valid_o), 1);
        chk("bypass_fwd_d", fwd_a_data_o, 32'h11);
        step(0, 0, 0, 0, 0, 0);
        chk("bypass_pending", 32'(pending_o), 0);

        // LSU and execute collide
        raddr_a_i = 5'd4;
        step(1, 5'd3, 32'hAA, 1, 5'd4, 32'hBB);
        chk_port("collide", 1, 5'd3, 32'hAA);
        chk("collide_ready", 32'(ex_ready_o), 1);
        chk("collide_fwd_none", 32'(fwd_a_valid_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("collide_pending", 32'(pending_o), 1);
        chk_port("collide_drain", 1, 5'd4, 32'hBB);
        chk("collide_fwd_q", fwd_a_data_o, 32'hBB);
        step(0, 0, 0, 0, 0, 0);
        chk("collide_empty", 32'(pending_o), 0);
        chk("collide_idle_we", 32'(rf_we_o), 0);

        // starvation under sustained LSU traffic
        step(1, 5'd1, 32'h100, 1, 5'd10, 32'hA0);
        chk("starve_rdy1", 32'(ex_ready_o), 1);
        step(1, 5'd1, 32'h101, 1, 5'd11, 32'hA1);
        chk("starve_rdy2", 32'(ex_ready_o), 1);
        step(1, 5'd1, 32'h102, 1, 5'd12, 32'hA2);
        chk("starve_rdy3", 32'(ex_ready_o), 0);
        step(1, 5'd1, 32'h103, 1, 5'd12, 32'hA2);
        chk("starve_rdy4", 32'(ex_ready_o), 0);
        chk_port("starve_lsu", 1, 5'd1, 32'h103);
        step(0, 0, 0, 0, 0, 0);
        chk_port("drain1", 1, 5'd10, 32'hA0);
        chk("drain1_rdy", 32'(ex_ready_o), 0);
        step(0, 0, 0, 1, 5'd12, 32'hA2);
        chk_port("drain2", 1, 5'd11, 32'hA1);
        chk("drain2_rdy", 32'(ex_ready_o), 1);
        step(0, 0, 0, 0, 0, 0);
        chk_port("drain3", 1, 5'd12, 32'hA2);
        step(0, 0, 0, 0, 0, 0);
        chk("drain_empty", 32'(pending_o), 0);
        chk("drain_rdy", 32'(ex_ready_o), 1);

        // LSU kills an older queued write to the same register
        raddr_a_i = 5'd7;
        step(1, 5'd2, 32'h50, 1, 5'd7, 32'h1);
        step(1, 5'd7, 32'h2, 0, 0, 0);
        chk_port("kill_lsu", 1, 5'd7, 32'h2);
        chk("kill_fwd_d", fwd_a_data_o, 32'h2);
        step(0, 0, 0, 0, 0, 0);
        chk("kill_pending", 32'(pending_o), 1);
        chk("kill_pop_we", 32'(rf_we_o), 0);
        chk("kill_fwd_v", 32'(fwd_a_valid_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("kill_empty", 32'(pending_o), 0);

        // same-cycle enqueue is younger than the LSU write and survives
        step(1, 5'd8, 32'h3, 1, 5'd8, 32'h4);
        chk_port("young_lsu", 1, 5'd8, 32'h3);
        step(0, 0, 0, 0, 0, 0);
        chk_port("young_pop", 1, 5'd8, 32'h4);

        // forwarding priority
        raddr_a_i = 5'd9;
        raddr_b_i = 5'd0;
        step(1, 5'd1, 32'h0, 1, 5'd9, 32'h5);
        step(1, 5'd1, 32'h0, 1, 5'd9, 32'h6);
        chk("fwd_old_d", fwd_a_data_o, 32'h5);
        step(1, 5'd1, 32'h0, 0, 0, 0);
        chk("fwd_young_v", 32'(fwd_a_valid_o), 1);
        chk("fwd_young_d", fwd_a_data_o, 32'h6);
        chk("fwd_b_zero", 32'(fwd_b_valid_o), 0);
        chk("fwd_full_rdy", 32'(ex_ready_o), 0);
        step(1, 5'd9, 32'h7, 0, 0, 0);
        chk("fwd_lsu_d", fwd_a_data_o, 32'h7);
        step(0, 0, 0, 0, 0, 0);
        chk("fwd_kill1_we", 32'(rf_we_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("fwd_kill2_we", 32'(rf_we_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("fwd_empty", 32'(pending_o), 0);

        // write to x0
        raddr_a_i = 5'd0;
        step(0, 0, 0, 1, 5'd0, 32'h99);
        chk("x0_ready", 32'(ex_ready_o), 1);
        chk("x0_we", 32'(rf_we_o), 0);
        chk("x0_fwd", 32'(fwd_a_valid_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("x0_pending", 32'(pending_o), 0);

        // reset with two entries queued
        step(1, 5'd1, 32'h0, 1, 5'd20, 32'h1);
        step(1, 5'd1, 32'h0, 1, 5'd21, 32'h2);
        step(1, 5'd1, 32'h0, 0, 0, 0);
        chk("rst2_pending", 32'(pending_o), 1);
        @(negedge clk_i);
        lsu_valid_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("rst2_pending_low", 32'(pending_o), 0);
        chk("rst2_ready", 32'(ex_ready_o), 1);
        chk("rst2_we", 32'(rf_we_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("rst2_after_we", 32'(rf_we_o), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst2_after_we2", 32'(rf_we_o), 0);
        chk("rst2_after_pending", 32'(pending_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
